inst_fetch_arbiter: RTL and testbench

Shares the single instruction-memory fetch port between the way0 and way1 instruction fetch units of the dual-issue front end. Each way presents a held request/address and receives a one-cycle dataOk pulse with the fetched instruction. The block arbitrates round-robin and keeps exactly one memory transaction outstanding. It also absorbs responses for transactions cancelled by a jump flush.

---
 rtl/b8_fetch_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 15 +
 rtl/inst_fetch_arbiter.sv | 103 ++++++++++
 tb/tb_inst_fetch_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/b8_fetch_arb_pkg.sv
// Shared types and constants for the instruction-fetch port arbiter.
// Combinational only; no latency and no backpressure of its own.
package b8_fetch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    localparam int ADDR_W_DFLT = 32;
    localparam int DATA_W_DFLT = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: the way that did not win last time wins a tie.
// Purely combinational (zero latency); it never stalls a requester.
module rr_arbiter2
    import b8_fetch_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ~last_grant : (req[1] ? WAY1 : WAY0);

endmodule

// File: rtl/inst_fetch_arbiter.sv
// Shares one instruction-memory fetch port between two fetch ways, round-robin.
// Request reaches memory one edge after it is sampled; dataOk returned in the memory response cycle.
// One transaction outstanding; other requester holds its request until granted and completed.
module inst_fetch_arbiter
    import b8_fetch_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              way0_request_i,
    input  logic [ADDR_W-1:0] way0_instAddr_i,
    input  logic              way0_flush_i,
    output logic              way0_dataOk_o,
    output logic [DATA_W-1:0] way0_inst_o,
    input  logic              way1_request_i,
    input  logic [ADDR_W-1:0] way1_instAddr_i,
    input  logic              way1_flush_i,
    output logic              way1_dataOk_o,
    output logic [DATA_W-1:0] way1_inst_o,
    output logic              mem_request_o,
    output logic [ADDR_W-1:0] mem_instAddr_o,
    input  logic              mem_dataOk_i,
    input  logic [DATA_W-1:0] mem_inst_i,
    output logic              busy_o
);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        req_vec;
    logic              pick_vld, pick_way;
    logic              flush_gnt, done, deliver;

    assign flush_gnt = (grant_q == WAY1) ? way1_flush_i : way0_flush_i;
    assign done      = (state_q != IDLE) && mem_dataOk_i;
    assign deliver   = (state_q == BUSY) && mem_dataOk_i && !flush_gnt;

    // The completing way still holds its request this cycle; mask it so it is not refetched.
    always_comb begin
        req_vec = {way1_request_i, way0_request_i};
        if (deliver) begin
            req_vec[grant_q] = 1'b0;
        end
    end

    rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .valid      (pick_vld),
        .winner     (pick_way)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_request_o;
        addr_d       = mem_instAddr_o;
        if (state_q == IDLE || done) begin
            if (pick_vld) begin
                state_d      = BUSY;
                grant_d      = pick_way;
                last_grant_d = pick_way;
                mem_req_d    = 1'b1;
                addr_d       = (pick_way == WAY1) ? way1_instAddr_i : way0_instAddr_i;
            end else begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        end else if (state_q == BUSY && flush_gnt) begin
            // Memory must still see the request held; only the response is dropped.
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            grant_q        <= WAY0;
            last_grant_q   <= WAY1;
            mem_request_o  <= 1'b0;
            mem_instAddr_o <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            mem_request_o  <= mem_req_d;
            mem_instAddr_o <= addr_d;
        end
    end

    assign way0_dataOk_o = deliver && (grant_q == WAY0);
    assign way1_dataOk_o = deliver && (grant_q == WAY1);
    assign way0_inst_o   = way0_dataOk_o ? mem_inst_i : '0;
    assign way1_inst_o   = way1_dataOk_o ? mem_inst_i : '0;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Directed bench for inst_fetch_arbiter with hand-computed expectations.
module tb_inst_fetch_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              way0_request_i, way0_flush_i, way0_dataOk_o;
    logic [ADDR_W-1:0] way0_instAddr_i;
    logic [DATA_W-1:0] way0_inst_o;
    logic              way1_request_i, way1_flush_i, way1_dataOk_o;
    logic [ADDR_W-1:0] way1_instAddr_i;
    logic [DATA_W-1:0] way1_inst_o;
    logic              mem_request_o, mem_dataOk_i, busy_o;
    logic [ADDR_W-1:0] mem_instAddr_o;
    logic [DATA_W-1:0] mem_inst_i;

    always #5 clk = ~clk;

    inst_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .way0_request_i  (way0_request_i),
        .way0_instAddr_i (way0_instAddr_i),
        .way0_flush_i    (way0_flush_i),
        .way0_dataOk_o   (way0_dataOk_o),
        .way0_inst_o     (way0_inst_o),
        .way1_request_i  (way1_request_i),
        .way1_instAddr_i (way1_instAddr_i),
        .way1_flush_i    (way1_flush_i),
        .way1_dataOk_o   (way1_dataOk_o),
        .way1_inst_o     (way1_inst_o),
        .mem_request_o   (mem_request_o),
        .mem_instAddr_o  (mem_instAddr_o),
        .mem_dataOk_i    (mem_dataOk_i),
        .mem_inst_i      (mem_inst_i),
        .busy_o          (busy_o)
    );

    int checks = 0;
    int failures = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    int both = 0;

    always @(posedge clk) begin
        if (way0_dataOk_o) cnt0++;
        if (way1_dataOk_o) cnt1++;
        if (way0_dataOk_o && way1_dataOk_o) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        way0_request_i  = 1'b0;
        way0_instAddr_i = '0;
        way0_flush_i    = 1'b0;
        way1_request_i  = 1'b0;
        way1_instAddr_i = '0;
        way1_flush_i    = 1'b0;
        mem_dataOk_i    = 1'b0;
        mem_inst_i      = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_request_o, 0);
        chk("rst_mem_addr", mem_instAddr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ok0", way0_dataOk_o, 0);
        chk("rst_ok1", way1_dataOk_o, 0);
        chk("rst_inst0", way0_inst_o, 0);
        reset_n = 1'b1;

        // Single way0 fetch, memory answers in the third request cycle.
        tick();
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h8000_0000;
        #1 chk("t1_req_not_yet", mem_request_o, 0);
        tick();
        chk("t1_req_c1", mem_request_o, 1);
        chk("t1_addr", mem_instAddr_o, 32'h8000_0000);
        chk("t1_busy", busy_o, 1);
        tick();
        chk("t1_req_c2", mem_request_o, 1);
        tick();
        chk("t1_req_c3", mem_request_o, 1);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0000_0013;
        #1;
        chk("t1_ok0", way0_dataOk_o, 1);
        chk("t1_inst0", way0_inst_o, 32'h13);
        chk("t1_ok1", way1_dataOk_o, 0);
        chk("t1_inst1", way1_inst_o, 0);
        tick();
        mem_dataOk_i   = 1'b0;
        way0_request_i = 1'b0;
        chk("t1_idle_req", mem_request_o, 0);
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_cnt0", cnt0, 1);

        // Both ways requesting continuously: strict alternation, no bubble.
        do_reset();
        tick();
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h100;
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_req", mem_request_o, 1);
            chk("t2_addr", mem_instAddr_o, (i % 2 == 0) ? 32'h100 : 32'h200);
            mem_dataOk_i = 1'b1;
            mem_inst_i   = 32'h1000 + i;
            #1;
            chk("t2_ok0", way0_dataOk_o, (i % 2 == 0) ? 1 : 0);
            chk("t2_ok1", way1_dataOk_o, (i % 2 == 0) ? 0 : 1);
            chk("t2_inst", (i % 2 == 0) ? way0_inst_o : way1_inst_o, 32'h1000 + i);
            tick();
        end

        // way1 flushed one cycle before its response: drain, then fetch the jump target.
        do_reset();
        tick();
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h40;
        tick();
        chk("t3_addr", mem_instAddr_o, 32'h40);
        tick();
        way1_flush_i    = 1'b1;
        way1_instAddr_i = 32'h80;
        #1 chk("t3_flush_ok1", way1_dataOk_o, 0);
        tick();
        way1_flush_i = 1'b0;
        chk("t3_drain_busy", busy_o, 1);
        chk("t3_drain_req", mem_request_o, 1);
        chk("t3_drain_addr", mem_instAddr_o, 32'h40);
        way1_flush_i = 1'b1;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hDEAD;
        #1;
        chk("t3_swallow_ok1", way1_dataOk_o, 0);
        chk("t3_swallow_ok0", way0_dataOk_o, 0);
        chk("t3_swallow_inst1", way1_inst_o, 0);
        tick();
        way1_flush_i = 1'b0;
        mem_dataOk_i = 1'b0;
        chk("t3_refetch_req", mem_request_o, 1);
        chk("t3_refetch_addr", mem_instAddr_o, 32'h80);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h55;
        #1;
        chk("t3_ok1", way1_dataOk_o, 1);
        chk("t3_inst1", way1_inst_o, 32'h55);
        tick();
        mem_dataOk_i   = 1'b0;
        way1_request_i = 1'b0;
        chk("t3_idle", busy_o, 0);

        // Flush coincident with response on way0; pending way1 granted on that edge.
        do_reset();
        tick();
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h300;
        tick();
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h400;
        chk("t4_addr0", mem_instAddr_o, 32'h300);
        tick();
        mem_dataOk_i   = 1'b1;
        mem_inst_i     = 32'hBEEF;
        way0_flush_i   = 1'b1;
        way0_request_i = 1'b0;
        #1;
        chk("t4_ok0", way0_dataOk_o, 0);
        chk("t4_inst0", way0_inst_o, 0);
        chk("t4_ok1_early", way1_dataOk_o, 0);
        tick();
        mem_dataOk_i = 1'b0;
        chk("t4_req1", mem_request_o, 1);
        chk("t4_addr1", mem_instAddr_o, 32'h400);
        tick();
        way0_flush_i = 1'b0;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h77;
        #1;
        chk("t4_ok1", way1_dataOk_o, 1);
        chk("t4_inst1", way1_inst_o, 32'h77);
        tick();
        mem_dataOk_i   = 1'b0;
        way1_request_i = 1'b0;

        // Reset mid-transaction, then a stray late response.
        do_reset();
        tick();
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h500;
        tick();
        chk("t5_busy_pre", busy_o, 1);
        reset_n        = 1'b0;
        way1_request_i = 1'b0;
        #1;
        chk("t5_rst_req", mem_request_o, 0);
        chk("t5_rst_addr", mem_instAddr_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        tick();
        reset_n = 1'b1;
        tick();
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hF00D;
        #1;
        chk("t5_stray_ok0", way0_dataOk_o, 0);
        chk("t5_stray_ok1", way1_dataOk_o, 0);
        tick();
        mem_dataOk_i = 1'b0;
        chk("t5_stray_busy", busy_o, 0);
        chk("t5_stray_req", mem_request_o, 0);
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h600;
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h700;
        tick();
        chk("t5_prio_addr", mem_instAddr_o, 32'h600);

        // Response strobe while idle with nobody requesting.
        do_reset();
        tick();
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h1234;
        #1;
        chk("t6_ok0", way0_dataOk_o, 0);
        chk("t6_ok1", way1_dataOk_o, 0);
        chk("t6_inst0", way0_inst_o, 0);
        tick();
        mem_dataOk_i = 1'b0;
        chk("t6_busy", busy_o, 0);
        chk("t6_req", mem_request_o, 0);

        chk("tot_cnt0", cnt0, 3);
        chk("tot_cnt1", cnt1, 4);
        chk("tot_both", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
